// File: rtl/rect_tool_ctrl.sv
// Purpose : rectangle-fill tool controller; debounces the mark button, captures two
//           cursor corners (live preview of corner 2) and asserts the fill code for one frame.
// Latency : state_rect and corners are registered (1 cycle after the deciding input);
//           a button edge reaches the FSM 2 sync + DEBOUNCE_CYCLES + 1 cycles later.
// Backpressure: none; inputs are sampled every cycle, and a press arriving in COMMIT is dropped.
// Ports   : clk, reset (async active-low); tool_en, btn_mark (raw), cancel, frame_tick,
//           cursor_x/y in; recg_{x,y}_pt{1,2} corners, state_rect (01 fill / 10 none),
//           rect_busy out.
// Option  : define RECT_SQUARE_EN to constrain every corner-2 load to a square around corner 1.
module rect_tool_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int H_MAX           = 639,
    parameter int V_MAX           = 479
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tool_en,
    input  logic       btn_mark,
    input  logic       cancel,
    input  logic       frame_tick,
    input  logic [9:0] cursor_x,
    input  logic [9:0] cursor_y,
    output logic [9:0] recg_x_pt1,
    output logic [9:0] recg_y_pt1,
    output logic [9:0] recg_x_pt2,
    output logic [9:0] recg_y_pt2,
    output logic [1:0] state_rect,
    output logic       rect_busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ANCHORED   = 2'd1,
        WAIT_FRAME = 2'd2,
        COMMIT     = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             sync1, sync2, stable, stable_d, press;
    logic [CNT_W-1:0] db_cnt;
    logic             ld_pt1, ld_pt2;
    logic [9:0]       cur_x_clamp, cur_y_clamp;
    logic [9:0]       pt2_x_nxt, pt2_y_nxt;

    // Button conditioning: two-flop synchroniser, then the stable level only follows
    // the synced level after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1    <= btn_mark;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                stable <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign press = stable & ~stable_d;

    assign cur_x_clamp = (cursor_x > 10'(H_MAX)) ? 10'(H_MAX) : cursor_x;
    assign cur_y_clamp = (cursor_y > 10'(V_MAX)) ? 10'(V_MAX) : cursor_y;

`ifdef RECT_SQUARE_EN
    // Square mode: step the same distance m = min(|dx|,|dy|) along both axes from
    // corner 1, in the direction of the cursor, then clamp back into the screen.
    logic signed [10:0] dx, dy;
    logic        [10:0] adx, ady, m;
    logic signed [11:0] sx, sy;

    always_comb begin
        dx = $signed({1'b0, cursor_x}) - $signed({1'b0, recg_x_pt1});
        dy = $signed({1'b0, cursor_y}) - $signed({1'b0, recg_y_pt1});
        adx = dx[10] ? 11'(-dx) : 11'(dx);
        ady = dy[10] ? 11'(-dy) : 11'(dy);
        m   = (adx < ady) ? adx : ady;
        sx  = dx[10] ? $signed({2'b00, recg_x_pt1}) - $signed({1'b0, m})
                     : $signed({2'b00, recg_x_pt1}) + $signed({1'b0, m});
        sy  = dy[10] ? $signed({2'b00, recg_y_pt1}) - $signed({1'b0, m})
                     : $signed({2'b00, recg_y_pt1}) + $signed({1'b0, m});
        pt2_x_nxt = sx[9:0];
        if (sx < 0)
            pt2_x_nxt = 10'd0;
        else if (sx > $signed(12'(H_MAX)))
            pt2_x_nxt = 10'(H_MAX);
        pt2_y_nxt = sy[9:0];
        if (sy < 0)
            pt2_y_nxt = 10'd0;
        else if (sy > $signed(12'(V_MAX)))
            pt2_y_nxt = 10'(V_MAX);
    end
`else
    assign pt2_x_nxt = cur_x_clamp;
    assign pt2_y_nxt = cur_y_clamp;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // cancel / tool deselect outrank press in ANCHORED; press outranks a same-cycle
    // frame_tick there. A tick coincident with entering WAIT_FRAME is consumed in
    // ANCHORED, so COMMIT always starts on the following tick.
    always_comb begin
        state_nxt = state;
        ld_pt1    = 1'b0;
        ld_pt2    = 1'b0;
        case (state)
            IDLE: begin
                if (press && tool_en) begin
                    state_nxt = ANCHORED;
                    ld_pt1    = 1'b1;
                end
            end
            ANCHORED: begin
                if (cancel || !tool_en) begin
                    state_nxt = IDLE;
                end else if (press) begin
                    state_nxt = WAIT_FRAME;
                    ld_pt2    = 1'b1;
                end else if (frame_tick) begin
                    ld_pt2    = 1'b1;
                end
            end
            WAIT_FRAME: begin
                if (cancel || !tool_en)
                    state_nxt = IDLE;
                else if (frame_tick)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                if (frame_tick)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Corner 1 anchors both corners to the clamped cursor; corner 2 then follows
    // the (optionally squared) target on each load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            recg_x_pt1 <= '0;
            recg_y_pt1 <= '0;
            recg_x_pt2 <= '0;
            recg_y_pt2 <= '0;
            state_rect <= 2'b10;
        end else begin
            if (ld_pt1) begin
                recg_x_pt1 <= cur_x_clamp;
                recg_y_pt1 <= cur_y_clamp;
                recg_x_pt2 <= cur_x_clamp;
                recg_y_pt2 <= cur_y_clamp;
            end else if (ld_pt2) begin
                recg_x_pt2 <= pt2_x_nxt;
                recg_y_pt2 <= pt2_y_nxt;
            end
            // Registered off the next state so the fill code lines up with the
            // cycle after the frame tick, i.e. pixel (0,0) of the filled frame.
            state_rect <= (state_nxt == COMMIT) ? 2'b01 : 2'b10;
        end
    end

    assign rect_busy = (state != IDLE);

endmodule

// File: tb/tb_rect_tool_ctrl.sv
// Purpose : self-checking bench for rect_tool_ctrl (DEBOUNCE_CYCLES=4).
// Latency : table ops settle fully before their expected record is popped and compared.
// Backpressure: n/a.
module tb_rect_tool_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tool_en = 1'b1;
    logic       btn_mark = 1'b0;
    logic       cancel = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] cursor_x = '0;
    logic [9:0] cursor_y = '0;
    logic [9:0] recg_x_pt1, recg_y_pt1, recg_x_pt2, recg_y_pt2;
    logic [1:0] state_rect;
    logic       rect_busy;

    int passed = 0;
    int total  = 0;

    rect_tool_ctrl #(.DEBOUNCE_CYCLES(4), .H_MAX(639), .V_MAX(479)) dut (
        .clk(clk), .reset(reset), .tool_en(tool_en), .btn_mark(btn_mark),
        .cancel(cancel), .frame_tick(frame_tick),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .recg_x_pt1(recg_x_pt1), .recg_y_pt1(recg_y_pt1),
        .recg_x_pt2(recg_x_pt2), .recg_y_pt2(recg_y_pt2),
        .state_rect(state_rect), .rect_busy(rect_busy)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_MOVE, OP_PRESS, OP_PRESS_FT, OP_PRESS_CN, OP_PRESS_NT,
                      OP_FRAME, OP_CANCEL, OP_TOOLOFF} op_t;

    typedef struct {
        op_t op;
        int  cx, cy;
        int  p1x, p1y, p2x, p2y;
        int  sr;
        int  busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic void add(op_t op, int cx, int cy, int p1x, int p1y,
                                int p2x, int p2y, int sr, int busy);
        vec_t v;
        v.op = op; v.cx = cx; v.cy = cy;
        v.p1x = p1x; v.p1y = p1y; v.p2x = p2x; v.p2y = p2y;
        v.sr = sr; v.busy = busy;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Button held long enough to debounce; the press pulse is live during the
    // 7th cycle, where the same-cycle side inputs are applied. Released afterwards
    // and held low until the stable level has returned to 0.
    task automatic do_press(input bit ft, input bit cn, input bit te);
        btn_mark = 1'b1;
        repeat (6) step();
        frame_tick = ft;
        cancel     = cn;
        tool_en    = te;
        step();
        frame_tick = 1'b0;
        cancel     = 1'b0;
        tool_en    = 1'b1;
        btn_mark   = 1'b0;
        repeat (7) step();
    endtask

    task automatic apply(input vec_t v);
        cursor_x = 10'(v.cx);
        cursor_y = 10'(v.cy);
        case (v.op)
            OP_MOVE:     repeat (3) step();
            OP_PRESS:    do_press(1'b0, 1'b0, 1'b1);
            OP_PRESS_FT: do_press(1'b1, 1'b0, 1'b1);
            OP_PRESS_CN: do_press(1'b0, 1'b1, 1'b1);
            OP_PRESS_NT: do_press(1'b0, 1'b0, 1'b0);
            OP_FRAME: begin
                frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
            end
            OP_CANCEL: begin
                cancel = 1'b1; step(); cancel = 1'b0; step();
            end
            OP_TOOLOFF: begin
                tool_en = 1'b0; step(); tool_en = 1'b1; step();
            end
            default: step();
        endcase
    endtask

    initial begin
        vec_t e;
        int   fill_cnt;

        // ---------------- vector table ----------------
        add(OP_MOVE,     100,  50,   0,   0,   0,   0, 2, 0);
        add(OP_PRESS,    100,  50, 100,  50, 100,  50, 2, 1);
        add(OP_MOVE,     200, 120, 100,  50, 100,  50, 2, 1);
`ifdef RECT_SQUARE_EN
        add(OP_FRAME,    200, 120, 100,  50, 170, 120, 2, 1);
        add(OP_PRESS,    210, 130, 100,  50, 180, 130, 2, 1);
`else
        add(OP_FRAME,    200, 120, 100,  50, 200, 120, 2, 1);
        add(OP_PRESS,    210, 130, 100,  50, 210, 130, 2, 1);
`endif
        add(OP_MOVE,       5,   5, 100,  50, vecs[4].p2x, vecs[4].p2y, 2, 1);
        add(OP_FRAME,      5,   5, 100,  50, vecs[4].p2x, vecs[4].p2y, 1, 1);
        add(OP_CANCEL,     5,   5, 100,  50, vecs[4].p2x, vecs[4].p2y, 1, 1);
        add(OP_PRESS,    300, 300, 100,  50, vecs[4].p2x, vecs[4].p2y, 1, 1);
        add(OP_FRAME,    300, 300, 100,  50, vecs[4].p2x, vecs[4].p2y, 2, 0);
        add(OP_PRESS,    700, 500, 639, 479, 639, 479, 2, 1);
`ifdef RECT_SQUARE_EN
        add(OP_FRAME,     10,  20, 639, 479, 180,  20, 2, 1);
`else
        add(OP_FRAME,     10,  20, 639, 479,  10,  20, 2, 1);
`endif
        add(OP_CANCEL,    10,  20, 639, 479, vecs[11].p2x, vecs[11].p2y, 2, 0);
        add(OP_PRESS_NT, 300, 300, 639, 479, vecs[11].p2x, vecs[11].p2y, 2, 0);
        add(OP_PRESS,    100, 100, 100, 100, 100, 100, 2, 1);
`ifdef RECT_SQUARE_EN
        add(OP_PRESS_FT, 130,  60, 100, 100, 130,  70, 2, 1);
`else
        add(OP_PRESS_FT, 130,  60, 100, 100, 130,  60, 2, 1);
`endif
        add(OP_MOVE,     130,  60, 100, 100, vecs[15].p2x, vecs[15].p2y, 2, 1);
        add(OP_TOOLOFF,  130,  60, 100, 100, vecs[15].p2x, vecs[15].p2y, 2, 0);
        add(OP_PRESS,     50,  60,  50,  60,  50,  60, 2, 1);
        add(OP_PRESS_CN,  90,  90,  50,  60,  50,  60, 2, 0);

        // ---------------- reset and glitch rejection ----------------
        reset = 1'b0;
        btn_mark = 1'b1;
        repeat (3) step();
        chk("rst pt1_x", int'(recg_x_pt1), 0);
        chk("rst pt2_y", int'(recg_y_pt2), 0);
        chk("rst state_rect", int'(state_rect), 2);
        chk("rst busy", int'(rect_busy), 0);
        btn_mark = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("post-rst state_rect", int'(state_rect), 2);
        chk("post-rst busy", int'(rect_busy), 0);

        cursor_x = 10'd77; cursor_y = 10'd33;
        btn_mark = 1'b1;
        repeat (3) step();
        btn_mark = 1'b0;
        repeat (10) step();
        chk("glitch busy", int'(rect_busy), 0);
        chk("glitch pt1_x", int'(recg_x_pt1), 0);

        // ---------------- table-driven section with scoreboard ----------------
        foreach (vecs[i]) begin
            apply(vecs[i]);
            sb.push_back(vecs[i]);
            e = sb.pop_front();
            chk($sformatf("v%0d pt1_x", i), int'(recg_x_pt1), e.p1x);
            chk($sformatf("v%0d pt1_y", i), int'(recg_y_pt1), e.p1y);
            chk($sformatf("v%0d pt2_x", i), int'(recg_x_pt2), e.p2x);
            chk($sformatf("v%0d pt2_y", i), int'(recg_y_pt2), e.p2y);
            chk($sformatf("v%0d state_rect", i), int'(state_rect), e.sr);
            chk($sformatf("v%0d busy", i), int'(rect_busy), e.busy);
        end

        // ---------------- fill lasts exactly one frame, cancel ignored ----------------
        cursor_x = 10'd20; cursor_y = 10'd30;
        do_press(1'b0, 1'b0, 1'b1);
        cursor_x = 10'd40; cursor_y = 10'd50;
        do_press(1'b0, 1'b0, 1'b1);
        chk("pre-commit state_rect", int'(state_rect), 2);
        fill_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (state_rect == 2'b01) fill_cnt++;
            for (int c = 1; c < 16; c++) begin
                cancel = (f == 0 && c == 5);
                step();
                cancel = 1'b0;
                if (state_rect == 2'b01) fill_cnt++;
            end
        end
        chk("fill cycles", fill_cnt, 16);
        chk("after fill busy", int'(rect_busy), 0);
        chk("after fill pt2_x", int'(recg_x_pt2), 40);

        // ---------------- asynchronous reset mid-COMMIT ----------------
        do_press(1'b0, 1'b0, 1'b1);
        do_press(1'b0, 1'b0, 1'b1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("commit state_rect", int'(state_rect), 1);
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        chk("async rst state_rect", int'(state_rect), 2);
        chk("async rst busy", int'(rect_busy), 0);
        chk("async rst pt1_x", int'(recg_x_pt1), 0);
        step();
        reset = 1'b1;
        step();
        chk("async rst release busy", int'(rect_busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
